// File: rtl/spi_pkg.sv
// ============================================================================
// Module : spi_pkg
// Brief  : Shared SPI receiver types and BNN command byte constants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam int SPI_BYTE_W = 8;

    localparam logic [SPI_BYTE_W-1:0] CMD_RESET  = 8'h00;
    localparam logic [SPI_BYTE_W-1:0] CMD_INPUT  = 8'hB1;
    localparam logic [SPI_BYTE_W-1:0] CMD_WEIGHT = 8'hB2;
    localparam logic [SPI_BYTE_W-1:0] CMD_BIAS   = 8'hB3;

endpackage

`default_nettype wire

// File: rtl/spi_sync.sv
// ============================================================================
// Module : spi_sync
// Brief  : SYNC_STAGES-deep synchroniser for one SPI pin with edge pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // No reset here: a cs_n held low through rst must not look like a new
    // falling edge once rst is released.
    always_ff @(posedge clk) begin
        chain <= {chain[SYNC_STAGES-2:0], din};
        prev  <= chain[SYNC_STAGES-1];
    end

    assign dout = chain[SYNC_STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

`default_nettype wire

// File: rtl/spi_cmd_rx.sv
// ============================================================================
// Module : spi_cmd_rx
// Brief  : Mode-0 SPI slave byte receiver feeding the BNN command decoder.
//          Build option SPI_ECHO_EN: MISO echoes the previous received byte.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_cmd_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sck,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic [7:0]       cmd_byte,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    input  logic [3:0]       results,
    output logic             frame_active,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             overrun,
    input  logic             err_clr
);

    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_ACTIVE = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
    logic unused_sck_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk (clk), .din (spi_sck), .dout (unused_sck_lvl),
        .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk (clk), .din (spi_cs_n), .dout (unused_cs_lvl),
        .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk (clk), .din (spi_mosi), .dout (mosi_s),
        .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic       tx_last;
    logic       rx_done;
    logic [7:0] reload;
    logic [7:0] start_load;

`ifdef SPI_ECHO_EN
    logic [3:0] unused_results;
    assign unused_results = results;
    assign reload         = rx_shift;
    assign start_load     = 8'h00;
`else
    assign reload         = {4'h0, results};
    assign start_load     = {4'h0, results};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            tx_shift <= 8'h00;
            spi_miso <= 1'b0;
            tx_last  <= 1'b0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state    <= ST_ACTIVE;
                        bit_cnt  <= 3'd0;
                        tx_shift <= start_load;
                        spi_miso <= start_load[7];
                        tx_last  <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state    <= ST_IDLE;
                        bit_cnt  <= 3'd0;
                        spi_miso <= 1'b0;
                        tx_last  <= 1'b0;
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[6:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_done <= 1'b1;
                            tx_last <= 1'b1;
                        end
                    end else if (sck_fall) begin
                        // The fall after the 8th rise presents the next byte's MSB.
                        if (tx_last) begin
                            tx_shift <= reload;
                            spi_miso <= reload[7];
                            tx_last  <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            spi_miso <= tx_shift[6];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_byte  <= 8'h00;
            cmd_valid <= 1'b0;
            byte_cnt  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (err_clr) begin
                overrun <= 1'b0;
            end
            if (rx_done) begin
                if (!cmd_valid || cmd_ready) begin
                    cmd_byte  <= rx_shift;
                    cmd_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
            if (state == ST_IDLE && cs_fall) begin
                byte_cnt <= '0;
            end else if (rx_done && byte_cnt != '1) begin
                byte_cnt <= byte_cnt + CNT_ONE;
            end
        end
    end

    assign frame_active = (state == ST_ACTIVE);

endmodule

`default_nettype wire
